// File: rtl/pc_unit_pkg.sv
// Shared MIPS fetch-stage definitions: default widths, exception vector,
// FSM state encoding and next-PC source selection.
package pc_unit_pkg;

  localparam int unsigned MIPS_DATA_WIDTH = 32;
  localparam logic [31:0] MIPS_EXC_VECTOR = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_EXC    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_STALL  = 3'd3,
    SEL_HALT   = 3'd4,
    SEL_SEQ    = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_next_mux.sv
// Combinational next-PC selection: exception > branch > jump > stall > halt > pc+4.
module pc_next_mux
  import pc_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = MIPS_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = DATA_WIDTH'(MIPS_EXC_VECTOR)
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  exception,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  stall,
  input  logic                  halt,
  output logic [DATA_WIDTH-1:0] next_pc,
  output pc_sel_e               sel
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  always_comb begin
    next_pc = pc_plus4;
    sel     = SEL_SEQ;
    if (exception) begin
      next_pc = EXC_VECTOR & ALIGN_MASK;
      sel     = SEL_EXC;
    end else if (branch_taken) begin
      next_pc = branch_target & ALIGN_MASK;
      sel     = SEL_BRANCH;
    end else if (jump) begin
      next_pc = jump_target & ALIGN_MASK;
      sel     = SEL_JUMP;
    end else if (stall) begin
      next_pc = pc;
      sel     = SEL_STALL;
    end else if (halt) begin
      next_pc = pc;
      sel     = SEL_HALT;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with IDLE/RUN/HALTED control, single-step support and a
// saturating count of fetch cycles.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = MIPS_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(MIPS_EXC_VECTOR),
  parameter int unsigned           CNT_WIDTH    = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic                  i_exception,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_target,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic                  o_fetch_en,
  output logic                  o_halted,
  output logic [1:0]            o_state,
  output logic [CNT_WIDTH-1:0]  o_fetch_count
);

  localparam logic [DATA_WIDTH-1:0] RESET_PC = RESET_VECTOR & ~DATA_WIDTH'(3);

  pc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] next_pc;
  logic [CNT_WIDTH-1:0]  cnt_q;
  pc_sel_e               sel;

  assign o_fetch_en    = (state_q == ST_RUN) && (!i_step_mode || i_step);
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + DATA_WIDTH'(4);
  assign o_halted      = (state_q == ST_HALTED);
  assign o_state       = state_q;
  assign o_fetch_count = cnt_q;

  pc_next_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_mux (
    .pc            (pc_q),
    .pc_plus4      (o_pc_plus4),
    .exception     (i_exception),
    .branch_taken  (i_branch_taken),
    .branch_target (i_branch_target),
    .jump          (i_jump),
    .jump_target   (i_jump_target),
    .stall         (i_stall),
    .halt          (i_halt),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_RUN;
      // Halt only wins when nothing above it in the priority chain claimed the cycle.
      ST_RUN:    if (o_fetch_en && sel == SEL_HALT) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (o_fetch_en) begin
        pc_q <= next_pc;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of PC, targets and vectors.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 32'h80, PC value loaded on exception.
REQ-004 Parameter CNT_WIDTH, default 32, width of the fetch-cycle counter.
REQ-005 i_clock  in  1  clock; all state updates on rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  leave IDLE and begin fetching.
REQ-008 i_step_mode  in  1  1 = advance only on i_step; 0 = continuous.
REQ-009 i_step  in  1  single-cycle advance pulse; used only in step mode.
REQ-010 i_stall  in  1  hazard-unit hold request.
REQ-011 i_halt  in  1  HALT instruction decoded at current PC.
REQ-012 i_exception  in  1  redirect to EXC_VECTOR.
REQ-013 i_branch_taken  in  1  taken branch resolved.
REQ-014 i_branch_target  in  DATA_WIDTH  branch destination.
REQ-015 i_jump  in  1  jump/jump-register resolved.
REQ-016 i_jump_target  in  DATA_WIDTH  jump destination.
REQ-017 o_pc  out  DATA_WIDTH  current fetch address.
REQ-018 o_pc_plus4  out  DATA_WIDTH  o_pc + 4, combinational.
REQ-019 o_fetch_en  out  1  this cycle is an active fetch/advance cycle.
REQ-020 o_halted  out  1  block is in HALTED.
REQ-021 o_state  out  2  encoded state (IDLE=0, RUN=1, HALTED=2).
REQ-022 o_fetch_count  out  CNT_WIDTH  number of fetch_en cycles since reset.

Function
REQ-023 States IDLE, RUN, HALTED; IDLE->RUN when i_start; RUN->HALTED per REQ-029; HALTED exits only via reset.
REQ-024 o_fetch_en = (state==RUN) && (!i_step_mode || i_step); combinational, zero latency.
REQ-025 PC, counter and state change only in cycles with o_fetch_en=1, except IDLE->RUN.
REQ-026 Next-PC priority when o_fetch_en=1: i_exception > i_branch_taken > i_jump > i_stall (hold) > i_halt (hold) > o_pc_plus4.
REQ-027 Redirects (exception/branch/jump) override i_stall and i_halt in the same cycle.
REQ-028 Targets have bits [1:0] forced to 0 before loading; o_pc[1:0] always 0.
REQ-029 i_halt with o_fetch_en=1 and no redirect: PC holds, state -> HALTED next cycle; i_stall with i_halt holds without halting.
REQ-030 o_pc_plus4 wraps modulo 2^DATA_WIDTH; all-ones-aligned PC advances to 0.
REQ-031 o_fetch_count increments by 1 per o_fetch_en cycle, including stall/hold cycles; saturates at all-ones.
REQ-032 In step mode, i_step held high N cycles yields N advances; i_step ignored outside RUN.
REQ-033 i_start ignored in RUN and HALTED; i_step_mode may change any cycle and takes effect the same cycle.

Reset
REQ-034 i_reset has priority over all inputs, including mid-redirect and mid-step.
REQ-035 Reset values: o_pc=RESET_VECTOR, state=IDLE, o_fetch_en=0, o_halted=0, o_fetch_count=0, o_pc_plus4=RESET_VECTOR+4.

Structure
REQ-036 State encodings, DATA_WIDTH default and EXC_VECTOR default SHALL live in the shared MIPS package.
REQ-037 Next-PC priority selection SHALL be a sub-module pc_next_mux (pure combinational); register, FSM and counter stay in pc_unit.

Verification
REQ-038 Reset, i_start, 5 cycles continuous -> o_pc 0,4,8,12,16,20; o_fetch_count=5.
REQ-039 Step mode, i_step pulsed 3 single cycles 4 cycles apart -> o_pc 0->4->8->12 only on pulse cycles; o_fetch_count=3.
REQ-040 At PC=0x10: i_stall 2 cycles, then i_stall+i_branch_taken target 0x43 -> PC holds 0x10 two cycles, then 0x40.
REQ-041 Same cycle i_exception, i_branch_taken(0x100), i_jump(0x200) -> PC=0x80; then i_jump alone 0x200 -> PC=0x200.
REQ-042 i_halt at PC=0x24 -> o_pc stays 0x24, o_halted=1, o_fetch_en=0; further i_start/i_step no effect; reset mid-halt -> IDLE, PC=0.
REQ-043 DATA_WIDTH=8, jump to 0xFC then advance -> o_pc 0xFC then 0x00.
